// File: rtl/cnn_pool_pkg.sv
// Shared types and defaults for the 2x2 pooling controller.
// Optional feature macro: POOL_AVG_EN (average pooling instead of max).
package cnn_pool_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned MAP_DIM_DEF = 4;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned IDX_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } pool_state_e;

  // Element address inside a window: 2*win + odd.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] win,
                                                  input logic              odd);
    return ADDR_W'({win, odd});
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// Per-window reduction: running max, or running sum when POOL_AVG_EN is defined.
// o_result_c already includes the element presented on i_data this cycle.
module pool_reduce
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_first,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_result_c
);

`ifdef POOL_AVG_EN
  localparam int unsigned SUM_W = DATA_W + 2;

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_sum = i_first ? SUM_W'(i_data) : r_sum + SUM_W'(i_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_sum <= '0;
    else if (i_en) r_sum <= w_sum;
  end

  assign o_result_c = DATA_W'(w_sum >> 2);
`else
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_max;

  // Strict compare so a tie keeps the earlier element.
  always_comb begin
    w_max = (i_first || (i_data > r_max)) ? i_data : r_max;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_max <= '0;
    else if (i_en) r_max <= w_max;
  end

  assign o_result_c = w_max;
`endif

endmodule

// File: rtl/pool2x2_ctrl.sv
// 2x2 stride-2 pooling controller: walks the feature map window by window,
// reduces each window and hands the result out with a valid/ready handshake.
// Optional feature macro: POOL_AVG_EN (selects average pooling in pool_reduce).
module pool2x2_ctrl
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MAP_DIM = MAP_DIM_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_row,
  output logic [ADDR_W-1:0] mem_col,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] pool_data,
  output logic [IDX_W-1:0]  pool_idx,
  output logic              pool_valid,
  input  logic              pool_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       WIN_DIM  = MAP_DIM / 2;
  localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN_DIM - 1);

  pool_state_e       r_state;
  logic [1:0]        r_k;
  logic [ADDR_W-1:0] r_wr;
  logic [ADDR_W-1:0] r_wc;

  logic              w_last_col;
  logic              w_last_win;
  logic [ADDR_W-1:0] w_nxt_wr;
  logic [ADDR_W-1:0] w_nxt_wc;
  logic [1:0]        w_k_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_result_c;

  // Next-window and next-element bookkeeping.
  always_comb begin
    w_last_col = (r_wc == WIN_LAST);
    w_last_win = w_last_col && (r_wr == WIN_LAST);
    w_nxt_wc   = w_last_col ? '0 : r_wc + ADDR_W'(1);
    w_nxt_wr   = w_last_col ? r_wr + ADDR_W'(1) : r_wr;
    w_k_nxt    = r_k + 2'd1;
    w_idx      = IDX_W'(r_wr * WIN_DIM + r_wc);
  end

  pool_reduce #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_state == ST_READ),
    .i_first    (r_k == 2'd0),
    .i_data     (mem_data),
    .o_result_c (w_result_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_wr       <= '0;
      r_wc       <= '0;
      mem_rd_en  <= 1'b0;
      mem_row    <= '0;
      mem_col    <= '0;
      pool_data  <= '0;
      pool_idx   <= '0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_READ;
            r_k       <= '0;
            r_wr      <= '0;
            r_wc      <= '0;
            mem_rd_en <= 1'b1;
            mem_row   <= '0;
            mem_col   <= '0;
            busy      <= 1'b1;
          end
        end
        ST_READ: begin
          if (r_k == 2'd3) begin
            r_state    <= ST_OUT;
            mem_rd_en  <= 1'b0;
            mem_row    <= '0;
            mem_col    <= '0;
            pool_data  <= w_result_c;
            pool_idx   <= w_idx;
            pool_valid <= 1'b1;
          end else begin
            r_k     <= w_k_nxt;
            mem_row <= elem_addr(r_wr, w_k_nxt[1]);
            mem_col <= elem_addr(r_wc, w_k_nxt[0]);
          end
        end
        ST_OUT: begin
          if (pool_ready) begin
            pool_valid <= 1'b0;
            if (w_last_win) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state   <= ST_READ;
              r_k       <= '0;
              r_wr      <= w_nxt_wr;
              r_wc      <= w_nxt_wc;
              mem_rd_en <= 1'b1;
              mem_row   <= elem_addr(w_nxt_wr, 1'b0);
              mem_col   <= elem_addr(w_nxt_wc, 1'b0);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool2x2_ctrl.sv
// Directed bench for pool2x2_ctrl with a 4x4 behavioural feature-map memory.
// Expected results follow POOL_AVG_EN the same way the design does.
module tb_pool2x2_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mem_rd_en;
  logic [2:0] mem_row;
  logic [2:0] mem_col;
  logic [7:0] mem_data;
  logic [7:0] pool_data;
  logic [1:0] pool_idx;
  logic       pool_valid;
  logic       pool_ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [4][4];

  int n_checks = 0;
  int n_errors = 0;

  int res_n;
  int res_data [4];
  int res_idx  [4];
  int done_at;
  int done_n;
  int rd_total;
  int exp_ramp [4];

  pool2x2_ctrl #(
    .DATA_W  (8),
    .MAP_DIM (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_row    (mem_row),
    .mem_col    (mem_col),
    .mem_data   (mem_data),
    .pool_data  (pool_data),
    .pool_idx   (pool_idx),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_data = mem[mem_row[1:0]][mem_col[1:0]];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mem[r][c] = 8'(4 * r + c);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mem[r][c] = v;
  endtask

  function automatic int unsigned all_outs();
    return {12'd0, mem_rd_en, mem_row, mem_col, pool_data, pool_idx, pool_valid, busy, done};
  endfunction

  // One full pass: checks addressing per cycle, collects results and done timing.
  task automatic do_pass(input int stall_idx, input int stall_len, input bit poke_start);
    int n;
    int stalled;
    int w;
    int k;
    int held;
    bit got_done;
    res_n    = 0;
    done_n   = 0;
    done_at  = 0;
    rd_total = 0;
    stalled  = 0;
    held     = 0;
    got_done = 0;
    pool_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!got_done && n < 100) begin
      start = 1'b0;
      if (done) begin
        got_done = 1;
        done_at  = n;
        done_n++;
        check("busy_in_done", busy, 0);
      end else begin
        check("busy_in_pass", busy, 1);
      end
      if (mem_rd_en) begin
        w = rd_total / 4;
        k = rd_total % 4;
        check("rd_row", mem_row, 2 * (w / 2) + k / 2);
        check("rd_col", mem_col, 2 * (w % 2) + k % 2);
        rd_total++;
      end else begin
        check("addr_idle", {mem_row, mem_col}, 0);
      end
      if (pool_valid) begin
        check("rd_en_in_out", mem_rd_en, 0);
        if (int'(pool_idx) == stall_idx && stalled < stall_len) begin
          if (stalled == 0) held = pool_data;
          else check("hold_data", pool_data, held);
          pool_ready = 1'b0;
          stalled++;
        end else begin
          pool_ready = 1'b1;
          if (res_n < 4) begin
            res_data[res_n] = pool_data;
            res_idx[res_n]  = pool_idx;
          end
          res_n++;
          if (poke_start && pool_idx == 2'd0) start = 1'b1;
        end
      end
      if (!got_done) begin
        tick();
        n++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    start = 1'b0;
    pool_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_n++;
    end
    check("busy_after", busy, 0);
  endtask

  task automatic check_pass(input string tag, input int exp [4], input int exp_done);
    check({tag, "_n"}, res_n, 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_data"}, res_data[i], exp[i]);
      check({tag, "_idx"}, res_idx[i], i);
    end
    check({tag, "_reads"}, rd_total, 16);
    check({tag, "_done_cyc"}, done_at, exp_done);
    check({tag, "_done_cnt"}, done_n, 1);
  endtask

  initial begin
    int exp_sat [4];
`ifdef POOL_AVG_EN
    exp_ramp = '{2, 4, 10, 12};
`else
    exp_ramp = '{5, 7, 13, 15};
`endif
    exp_sat = '{255, 255, 255, 255};
    reset = 1'b0;
    start = 1'b0;
    pool_ready = 1'b1;
    fill_ramp();
    tick();
    tick();
    check("reset_outs", all_outs(), 0);
    reset = 1'b1;
    tick();
    check("idle_outs", all_outs(), 0);

    do_pass(-1, 0, 1'b0);
    check_pass("ramp", exp_ramp, 21);

    do_pass(1, 3, 1'b0);
    check_pass("stall", exp_ramp, 24);

    do_pass(-1, 0, 1'b1);
    check_pass("start_busy", exp_ramp, 21);

    fill_const(8'hFF);
    do_pass(-1, 0, 1'b0);
    check_pass("sat", exp_sat, 21);

    // Reset during the second read of window 2.
    fill_ramp();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("mid_rd_en", mem_rd_en, 1);
    check("mid_pool_data", pool_data, exp_ramp[1]);
    reset = 1'b0;
    #1;
    check("mid_rst_outs", all_outs(), 0);
    tick();
    check("mid_rst_hold", all_outs(), 0);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_idle", all_outs(), 0);
    do_pass(-1, 0, 1'b0);
    check_pass("fresh", exp_ramp, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
